// File: rtl/vram_pkg.sv
// Shared defaults, grant encoding and starvation limit for the VRAM arbiter.
package vram_pkg;

    localparam int VRAM_ADDR_W     = 19;
    localparam int VRAM_DATA_W     = 12;
    localparam int VRAM_IMG_W      = 512;
    localparam int VRAM_IMG_H      = 512;
    localparam int VRAM_FIFO_DEPTH = 4;
    localparam int STEAL_LIMIT     = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DISP  = 2'd1,
        WRITE = 2'd2,
        STEAL = 2'd3
    } grant_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous first-word-fall-through write buffer with occupancy output.
module vram_wr_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (PW+1)'(DEPTH));
    assign do_push = push && !full;
    // Pop is qualified by the registered level, so a word pushed into an
    // empty buffer cannot leave in the same cycle.
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (PW+1)'(1);
                2'b01:   level <= level - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scan-out has priority over buffered writes.
// Optional display-steal starvation relief is enabled with `define VRAM_ARB_STEAL_EN.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int DATA_W     = VRAM_DATA_W,
    parameter int IMG_W      = VRAM_IMG_W,
    parameter int IMG_H      = VRAM_IMG_H,
    parameter int FIFO_DEPTH = VRAM_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          disp_valid,
    input  logic [9:0]                    h_addr,
    input  logic [9:0]                    v_addr,
    output logic [DATA_W-1:0]             pix_data,
    output logic                          pix_valid,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_wdata,
    output logic                          ram_we,
    input  logic [DATA_W-1:0]             ram_q,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam logic [ADDR_W:0] IMG_PIX = (ADDR_W+1)'(IMG_W * IMG_H);

    logic                     disp_req;
    logic [ADDR_W-1:0]        disp_addr;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [ADDR_W+DATA_W-1:0] fifo_head;
    logic [ADDR_W-1:0]        head_addr;
    logic [DATA_W-1:0]        head_data;
    logic                     head_in_range;
    logic                     steal_due;
    grant_t                   grant;
    grant_t                   gnt_p0;
    grant_t                   gnt_p1;
    logic                     vld_p0;
    logic                     vld_p1;
    logic [ADDR_W-1:0]        addr_nxt;
    logic [DATA_W-1:0]        wdata_nxt;
    logic                     we_nxt;

    assign wr_ready  = reset && !fifo_full;
    assign fifo_push = wr_valid && wr_ready;
    assign fifo_pop  = (grant == WRITE) || (grant == STEAL);

    vram_wr_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({wr_addr, wr_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    assign head_addr     = fifo_head[ADDR_W+DATA_W-1:DATA_W];
    assign head_data     = fifo_head[DATA_W-1:0];
    assign head_in_range = ({1'b0, head_addr} < IMG_PIX);

    // Column-major image layout.
    assign disp_req  = disp_valid && (32'(h_addr) < IMG_W) && (32'(v_addr) < IMG_H);
    assign disp_addr = ADDR_W'(h_addr) * ADDR_W'(IMG_H) + ADDR_W'(v_addr);

`ifdef VRAM_ARB_STEAL_EN
    localparam int CNT_W = $clog2(STEAL_LIMIT + 1);

    logic [CNT_W-1:0] steal_cnt;

    assign steal_due = (steal_cnt == CNT_W'(STEAL_LIMIT));

    // Counts consecutive cycles the buffer sits full without draining.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            steal_cnt <= '0;
        end else if (fifo_pop || !fifo_full) begin
            steal_cnt <= '0;
        end else if (!steal_due) begin
            steal_cnt <= steal_cnt + CNT_W'(1);
        end
    end
`else
    assign steal_due = 1'b0;
`endif

    always_comb begin
        grant = IDLE;
        if (disp_req) begin
            grant = (steal_due && !fifo_empty) ? STEAL : DISP;
        end else if (!fifo_empty) begin
            grant = WRITE;
        end
    end

    always_comb begin
        addr_nxt  = '0;
        wdata_nxt = '0;
        we_nxt    = 1'b0;
        case (grant)
            DISP: addr_nxt = disp_addr;
            WRITE, STEAL: begin
                if (head_in_range) begin
                    addr_nxt  = head_addr;
                    wdata_nxt = head_data;
                    we_nxt    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Stage p0: RAM command issue; stage p1: RAM read in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            vld_p0    <= 1'b0;
            gnt_p0    <= IDLE;
            vld_p1    <= 1'b0;
            gnt_p1    <= IDLE;
        end else begin
            ram_addr  <= addr_nxt;
            ram_wdata <= wdata_nxt;
            ram_we    <= we_nxt;
            vld_p0    <= disp_valid;
            gnt_p0    <= grant;
            vld_p1    <= vld_p0;
            gnt_p1    <= gnt_p0;
        end
    end

    // Stage p2: pixel capture; a stolen slot repeats the last delivered pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            pix_valid <= vld_p1;
            case (gnt_p1)
                DISP:    pix_data <= ram_q;
                STEAL:   pix_data <= pix_data;
                default: pix_data <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed display/write vectors, monitor-side checking.
`timescale 1ns/1ps
module tb_vram_arbiter;

    localparam int ADDR_W     = 19;
    localparam int DATA_W     = 12;
    localparam int IMG_W      = 512;
    localparam int IMG_H      = 512;
    localparam int FIFO_DEPTH = 4;
`ifdef VRAM_ARB_STEAL_EN
    localparam int STEAL_ON   = 1;
`else
    localparam int STEAL_ON   = 0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              disp_valid = 1'b0;
    logic [9:0]        h_addr = '0;
    logic [9:0]        v_addr = '0;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q = '0;
    logic [2:0]        fifo_level;

    vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .disp_valid(disp_valid), .h_addr(h_addr), .v_addr(v_addr),
        .pix_data(pix_data), .pix_valid(pix_valid), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_q(ram_q), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: background pattern plus any addresses written.
    logic [DATA_W-1:0] mem_wr [int];

    function automatic logic [DATA_W-1:0] pat(input int a);
        return DATA_W'(a * 37 + 11);
    endfunction

    function automatic logic [DATA_W-1:0] rd(input int a);
        if (mem_wr.exists(a)) return mem_wr[a];
        return pat(a);
    endfunction

    always @(posedge clk) begin
        ram_q <= rd(int'(ram_addr));
        if (ram_we) mem_wr[int'(ram_addr)] = ram_wdata;
    end

    typedef struct { int due; logic [DATA_W-1:0] data; } pix_exp_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_exp_t;

    pix_exp_t          pix_q[$];
    wr_exp_t           wr_q[$];
    pix_exp_t          pe;
    wr_exp_t           we;
    int                tests = 0;
    int                fails = 0;
    int                wr_seen = 0;
    logic [DATA_W-1:0] last_exp = '0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        while (pix_q.size() > 0 && pix_q[0].due < cyc) begin
            pe = pix_q.pop_front();
            tests++;
            fails++;
            $display("FAIL pix_missing: no pixel at cycle %0d, required data 0x%0h", pe.due, pe.data);
        end
        if (pix_valid) begin
            tests++;
            if (pix_q.size() == 0) begin
                fails++;
                $display("FAIL pix_unexpected: got data 0x%0h at cycle %0d, required no pixel", pix_data, cyc);
            end else begin
                pe = pix_q.pop_front();
                if (pe.due != cyc || pe.data != pix_data) begin
                    fails++;
                    $display("FAIL pix_data: got 0x%0h at cycle %0d, required 0x%0h at cycle %0d",
                             pix_data, cyc, pe.data, pe.due);
                end
            end
        end
        if (ram_we) begin
            wr_seen++;
            tests++;
            if (wr_q.size() == 0) begin
                fails++;
                $display("FAIL ram_write_unexpected: got addr 0x%0h data 0x%0h, required no write", ram_addr, ram_wdata);
            end else begin
                we = wr_q.pop_front();
                if (we.addr != ram_addr || we.data != ram_wdata) begin
                    fails++;
                    $display("FAIL ram_write: got addr 0x%0h data 0x%0h, required addr 0x%0h data 0x%0h",
                             ram_addr, ram_wdata, we.addr, we.data);
                end
            end
        end
    end

    // One cycle of stimulus; expectations are queued as the vector is issued.
    task automatic drive(input bit dv, input int h, input int v, input bit wv,
                         input int wa, input int wd, input bit acc, input bit stl);
        logic [DATA_W-1:0] e;
        disp_valid = dv;
        h_addr     = 10'(h);
        v_addr     = 10'(v);
        wr_valid   = wv;
        wr_addr    = ADDR_W'(wa);
        wr_data    = DATA_W'(wd);
        e = '0;
        if (dv) begin
            if (stl) e = last_exp;
            else if (h < IMG_W && v < IMG_H) e = rd(h * IMG_H + v);
            pix_q.push_back('{due: cyc + 3, data: e});
        end
        last_exp = e;
        if (wv) begin
            chk("wr_ready", wr_ready, acc);
            if (acc && wa < IMG_W * IMG_H) wr_q.push_back('{addr: ADDR_W'(wa), data: DATA_W'(wd)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_pix_data"},   pix_data,   0);
        chk({tag, "_pix_valid"},  pix_valid,  0);
        chk({tag, "_ram_addr"},   ram_addr,   0);
        chk({tag, "_ram_wdata"},  ram_wdata,  0);
        chk({tag, "_ram_we"},     ram_we,     0);
        chk({tag, "_wr_ready"},   wr_ready,   0);
        chk({tag, "_fifo_level"}, fifo_level, 0);
    endtask

    int seen0;

    initial begin
        mem_wr[514] = 12'hABC;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_vals("rst");
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("wr_ready_after_release", wr_ready, 1);

        // Display reads: address h*IMG_H+v, 3-cycle latency.
        drive(1, 1, 2, 0, 0, 0, 0, 0);
        chk("disp_addr_1_2", ram_addr, 514);
        chk("disp_we", ram_we, 0);
        drive(1, 1, 1, 0, 0, 0, 0, 0);
        chk("disp_addr_1_1", ram_addr, 513);
        drive(1, 3, 7, 0, 0, 0, 0, 0);
        chk("disp_addr_3_7", ram_addr, 1543);
        idle(3);

        // Single write with the display idle.
        drive(0, 0, 0, 1, 5, 'h123, 1, 0);
        chk("level_after_push", fifo_level, 1);
        idle(1);
        chk("wr_ram_we", ram_we, 1);
        chk("wr_ram_addr", ram_addr, 5);
        chk("wr_ram_wdata", ram_wdata, 'h123);
        chk("level_after_pop", fifo_level, 0);

        // Out-of-range write is dropped; simultaneous push/pop keeps level.
        drive(0, 0, 0, 1, IMG_W * IMG_H, 'h777, 1, 0);
        drive(0, 0, 0, 1, 6, 'h456, 1, 0);
        chk("discard_we", ram_we, 0);
        chk("pushpop_level", fifo_level, 1);
        idle(1);
        chk("after_discard_addr", ram_addr, 6);
        idle(2);

        // Continuous display blocks writes; fifth push is refused.
        seen0 = wr_seen;
        for (int i = 0; i < 5; i++) drive(1, 2, i, 1, 40 + i, 'h900 + i, i < 4, 0);
        for (int i = 5; i < 15; i++) drive(1, 2, i, 0, 0, 0, 0, 0);
        chk("full_level", fifo_level, 4);
        chk("full_wr_ready", wr_ready, 0);
        chk("blocked_writes", wr_seen - seen0, 0);
        idle(7);
        chk("drained_writes", wr_seen - seen0, 4);
        chk("drained_level", fifo_level, 0);

        // Out-of-range scan position lets a buffered write through.
        drive(0, 0, 0, 1, 7, 'h3C5, 1, 0);
        drive(1, 600, 3, 0, 0, 0, 0, 0);
        chk("oor_write_we", ram_we, 1);
        chk("oor_write_addr", ram_addr, 7);
        drive(1, 5, 512, 0, 0, 0, 0, 0);
        drive(1, 1, 2, 0, 0, 0, 0, 0);
        idle(4);

        // Starvation window with a full buffer.
        seen0 = wr_seen;
        for (int i = 0; i < 4; i++) drive(1, 4, i, 1, 60 + i, 'h510 + i, 1, 0);
        for (int j = 0; j < 70; j++) drive(1, 4, 4 + j, 0, 0, 0, 0, STEAL_ON != 0 && j == 64);
        chk("starve_writes", wr_seen - seen0, STEAL_ON);
        chk("starve_level", fifo_level, 4 - STEAL_ON);
        idle(7);
        chk("starve_drained", wr_seen - seen0, 4);

        // Reset mid-operation with three writes buffered.
        for (int i = 0; i < 3; i++) drive(1, 6, i, 1, 80 + i, 'h600 + i, 1, 0);
        chk("pre_reset_level", fifo_level, 3);
        #2 reset = 1'b0;
        #1;
        reset_vals("midrst");
        pix_q.delete();
        wr_q.delete();
        last_exp = '0;
        disp_valid = 1'b0;
        wr_valid   = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_wr_ready", wr_ready, 1);
        chk("post_reset_level", fifo_level, 0);
        seen0 = wr_seen;
        idle(5);
        chk("no_stale_writes", wr_seen - seen0, 0);
        drive(1, 1, 2, 1, 9, 'hDEF, 1, 0);
        idle(5);
        chk("post_reset_write", wr_seen - seen0, 1);

        chk("pix_queue_empty", pix_q.size(), 0);
        chk("wr_queue_empty", wr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, required completion");
        $fatal(1);
    end

endmodule
